// File: rtl/morse_pkg.sv
// Shared Morse definitions: entry codes, FSM states, pattern decode and seven-segment glyphs.
// Pure combinational helpers, no latency; no flow control involved.
package morse_pkg;

    localparam logic [5:0] CODE_SPACE = 6'd36;
    localparam logic [5:0] CODE_ERR   = 6'd37;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WORD
    } state_t;

    // bits holds the elements with the latest in bit 0 (dot = 0, dash = 1).
    function automatic logic [5:0] morse_decode(input logic [2:0] len, input logic [4:0] bits);
        logic [5:0] code;
        code = CODE_ERR;
        case (len)
            3'd1: code = bits[0] ? 6'd29 : 6'd14;
            3'd2: begin
                case (bits[1:0])
                    2'b00:   code = 6'd18;
                    2'b01:   code = 6'd10;
                    2'b10:   code = 6'd23;
                    default: code = 6'd22;
                endcase
            end
            3'd3: begin
                case (bits[2:0])
                    3'b000:  code = 6'd28;
                    3'b001:  code = 6'd30;
                    3'b010:  code = 6'd27;
                    3'b011:  code = 6'd32;
                    3'b100:  code = 6'd13;
                    3'b101:  code = 6'd20;
                    3'b110:  code = 6'd16;
                    default: code = 6'd24;
                endcase
            end
            3'd4: begin
                case (bits[3:0])
                    4'b0000: code = 6'd17;
                    4'b0001: code = 6'd31;
                    4'b0010: code = 6'd15;
                    4'b0100: code = 6'd21;
                    4'b0110: code = 6'd25;
                    4'b0111: code = 6'd19;
                    4'b1000: code = 6'd11;
                    4'b1001: code = 6'd33;
                    4'b1010: code = 6'd12;
                    4'b1011: code = 6'd34;
                    4'b1100: code = 6'd35;
                    4'b1101: code = 6'd26;
                    default: code = CODE_ERR;
                endcase
            end
            3'd5: begin
                case (bits)
                    5'b11111: code = 6'd0;
                    5'b01111: code = 6'd1;
                    5'b00111: code = 6'd2;
                    5'b00011: code = 6'd3;
                    5'b00001: code = 6'd4;
                    5'b00000: code = 6'd5;
                    5'b10000: code = 6'd6;
                    5'b11000: code = 6'd7;
                    5'b11100: code = 6'd8;
                    5'b11110: code = 6'd9;
                    default:  code = CODE_ERR;
                endcase
            end
            default: code = CODE_ERR;
        endcase
        return code;
    endfunction

    // Segment order {g,f,e,d,c,b,a}; letters use the usual mixed-case approximations.
    function automatic logic [6:0] morse_glyph(input logic [5:0] code);
        logic [6:0] seg;
        seg = 7'h00;
        case (code)
            6'd0:  seg = 7'h3F;
            6'd1:  seg = 7'h06;
            6'd2:  seg = 7'h5B;
            6'd3:  seg = 7'h4F;
            6'd4:  seg = 7'h66;
            6'd5:  seg = 7'h6D;
            6'd6:  seg = 7'h7D;
            6'd7:  seg = 7'h07;
            6'd8:  seg = 7'h7F;
            6'd9:  seg = 7'h6F;
            6'd10: seg = 7'h77;
            6'd11: seg = 7'h7C;
            6'd12: seg = 7'h39;
            6'd13: seg = 7'h5E;
            6'd14: seg = 7'h79;
            6'd15: seg = 7'h71;
            6'd16: seg = 7'h3D;
            6'd17: seg = 7'h76;
            6'd18: seg = 7'h30;
            6'd19: seg = 7'h1E;
            6'd20: seg = 7'h75;
            6'd21: seg = 7'h38;
            6'd22: seg = 7'h55;
            6'd23: seg = 7'h54;
            6'd24: seg = 7'h5C;
            6'd25: seg = 7'h73;
            6'd26: seg = 7'h67;
            6'd27: seg = 7'h50;
            6'd28: seg = 7'h6D;
            6'd29: seg = 7'h78;
            6'd30: seg = 7'h3E;
            6'd31: seg = 7'h1C;
            6'd32: seg = 7'h2A;
            6'd33: seg = 7'h76;
            6'd34: seg = 7'h6E;
            6'd35: seg = 7'h5B;
            6'd37: seg = 7'h40;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for the Morse key.
// Latency: 2 + DEBOUNCE_CYCLES cycles from button edge to key edge.
// No backpressure: the raw button is sampled every cycle.
module morse_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic key
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_0;
    logic          sync_1;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_0     <= 1'b0;
            sync_1     <= 1'b0;
            stable_cnt <= '0;
            key        <= 1'b0;
        end else begin
            sync_0 <= button;
            sync_1 <= sync_0;
            // Any agreement with the accepted level restarts the stability window.
            if (sync_1 == key) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                key        <= sync_1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_rx_buffer.sv
// Morse key receiver: times presses/gaps, decodes characters and shifts glyphs into a digit buffer.
// Latency: entry appears one cycle after the gap counter reaches 3 or 7 units.
// No backpressure: char_valid is a single-cycle strobe the consumer must take.
module morse_rx_buffer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_SYMBOLS     = 5,
    parameter int NUM_DIGITS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    button,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    char_valid,
    output logic [5:0]              char_code,
    output logic [2:0]              sym_count,
    output logic                    overflow
);

    localparam int            CW        = $clog2(7 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] PRESS_SAT = CW'(2 * UNIT_CYCLES);
    localparam logic [CW-1:0] CHAR_GAP  = CW'(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] WORD_GAP  = CW'(7 * UNIT_CYCLES);
    localparam logic [2:0]    MAX_SYM   = 3'(MAX_SYMBOLS);

    logic          key;
    logic          key_d;
    logic          key_rise;
    logic          key_fall;
    logic [CW-1:0] press_cnt;
    logic [CW-1:0] gap_cnt;
    // Only five elements can ever decode to a glyph, so longer symbols need no extra bits.
    logic [4:0]    symbol;
    state_t        state_q;
    state_t        state_d;
    logic          emit_char;
    logic          emit_space;
    logic [5:0]    emit_code;
    logic [6:0]    digits [NUM_DIGITS];

    morse_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .key    (key)
    );

    assign key_rise = key & ~key_d;
    assign key_fall = ~key & key_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_d     <= 1'b0;
            press_cnt <= '0;
            gap_cnt   <= '0;
            state_q   <= IDLE;
        end else begin
            key_d     <= key;
            state_q   <= state_d;
            press_cnt <= !key ? '0 : (press_cnt == PRESS_SAT) ? press_cnt : press_cnt + 1'b1;
            gap_cnt   <= key ? '0 : (gap_cnt == WORD_GAP) ? gap_cnt : gap_cnt + 1'b1;
        end
    end

    // A rise coinciding with a gap threshold still emits; the press then opens a new character.
    always_comb begin
        state_d    = state_q;
        emit_char  = 1'b0;
        emit_space = 1'b0;
        case (state_q)
            IDLE:  if (key_rise) state_d = PRESS;
            PRESS: if (key_fall) state_d = GAP;
            GAP: begin
                if (gap_cnt == CHAR_GAP) begin
                    emit_char = 1'b1;
                    state_d   = key_rise ? PRESS : WORD;
                end else if (key_rise) begin
                    state_d = PRESS;
                end
            end
            WORD: begin
                if (gap_cnt == WORD_GAP) begin
                    emit_space = 1'b1;
                    state_d    = key_rise ? PRESS : IDLE;
                end else if (key_rise) begin
                    state_d = PRESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        emit_code = overflow ? CODE_ERR : morse_decode(sym_count, symbol);
        if (emit_space) emit_code = CODE_SPACE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            symbol    <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
        end else if (emit_char) begin
            symbol    <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
        end else if (key_fall) begin
            if (sym_count == MAX_SYM) begin
                overflow <= 1'b1;
            end else begin
                symbol    <= {symbol[3:0], (press_cnt >= PRESS_SAT)};
                sym_count <= sym_count + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            char_valid <= 1'b0;
            char_code  <= CODE_SPACE;
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
        end else begin
            char_valid <= emit_char | emit_space;
            if (emit_char | emit_space) begin
                char_code <= emit_code;
                for (int i = NUM_DIGITS - 1; i > 0; i--) digits[i] <= digits[i-1];
                digits[0] <= morse_glyph(emit_code);
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        assign seg_out[7*g +: 7] = digits[g];
    end

endmodule

// File: tb/tb_morse_rx_buffer.sv
// Randomised and directed checks of morse_rx_buffer against an ITU-table reference model.
module tb_morse_rx_buffer;

    localparam int UNIT = 10;
    localparam int DEB  = 2;
    localparam int MAXS = 5;
    localparam int ND   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          button;
    logic [27:0]   seg_out;
    logic          char_valid;
    logic [5:0]    char_code;
    logic [2:0]    sym_count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    morse_rx_buffer #(
        .UNIT_CYCLES     (UNIT),
        .DEBOUNCE_CYCLES (DEB),
        .MAX_SYMBOLS     (MAXS),
        .NUM_DIGITS      (ND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .seg_out    (seg_out),
        .char_valid (char_valid),
        .char_code  (char_code),
        .sym_count  (sym_count),
        .overflow   (overflow)
    );

    // Index = code: digits 0-9 then A-Z.
    string morse_tab [36] = '{
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
        "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    logic [6:0] glyph_tab [38] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E, 7'h75, 7'h38, 7'h55,
        7'h54, 7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A, 7'h76, 7'h6E, 7'h5B,
        7'h00, 7'h40};

    int          got_code [$];
    logic [27:0] got_seg  [$];
    int          exp_code [$];
    logic [27:0] exp_seg  [$];
    logic [6:0]  mdig [ND];

    always @(negedge clk) begin
        if (char_valid === 1'b1) begin
            got_code.push_back(int'(char_code));
            got_seg.push_back(seg_out);
        end
    end

    function automatic int code_of(string pat);
        if (pat.len() > MAXS) return 37;
        for (int i = 0; i < 36; i++) if (morse_tab[i] == pat) return i;
        return 37;
    endfunction

    function automatic logic [27:0] model_seg();
        logic [27:0] s;
        for (int i = 0; i < ND; i++) s[7*i +: 7] = mdig[i];
        return s;
    endfunction

    task automatic model_emit(int code);
        for (int i = ND - 1; i > 0; i--) mdig[i] = mdig[i-1];
        mdig[0] = glyph_tab[code];
        exp_code.push_back(code);
        exp_seg.push_back(model_seg());
    endtask

    task automatic do_reset();
        button = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < ND; i++) mdig[i] = '0;
        got_code.delete(); got_seg.delete(); exp_code.delete(); exp_seg.delete();
    endtask

    task automatic press(int p, int g);
        button = 1'b1;
        repeat (p) @(negedge clk);
        button = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    // A gap of 30+ cycles closes the character, 70+ also yields a word space.
    task automatic send(string pat, int gap, bit rnd);
        int p;
        int g;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "-")
                p = !rnd ? 30 : ($urandom_range(5, 0) == 0) ? $urandom_range(300, 61) : $urandom_range(60, 22);
            else
                p = rnd ? $urandom_range(18, 4) : 10;
            g = (i == pat.len() - 1) ? gap : (rnd ? $urandom_range(25, 4) : 10);
            press(p, g);
        end
        if (gap >= 3 * UNIT) model_emit(code_of(pat));
        if (gap >= 7 * UNIT) model_emit(36);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (seg_out !== '0 || char_code !== 6'd36 || sym_count !== 3'd0 || overflow !== 1'b0 || char_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: seg=%h code=%0d sym=%0d ovf=%b vld=%b, want 0/36/0/0/0", seg_out, char_code, sym_count, overflow, char_valid);
        end
        repeat (200) @(negedge clk);
        total++;
        if (got_code.size() != 0) begin
            bad++;
            $display("FAIL reset_idle_pulses: got %0d pulses, want 0", got_code.size());
        end
        total++;
        if (seg_out !== '0 || char_code !== 6'd36) begin
            bad++;
            $display("FAIL reset_idle_outputs: seg=%h code=%0d, want 0/36", seg_out, char_code);
        end
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        press(10, 10);
        button = 1'b1;
        repeat (30) @(negedge clk);
        button = 1'b0;
        lat = 0;
        while (char_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 35) begin
            bad++;
            $display("FAIL single_latency: pulse after %0d cycles, want 35", lat);
        end
        repeat (5) @(negedge clk);
        model_emit(10);
        total++;
        if (got_code.size() != exp_code.size()) begin
            bad++;
            $display("FAIL single_count: got %0d pulses, want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            total++;
            if (got_code[i] !== exp_code[i] || got_seg[i] !== exp_seg[i]) begin
                bad++;
                $display("FAIL single_entry%0d: code %0d seg %h, want %0d seg %h", i, got_code[i], got_seg[i], exp_code[i], exp_seg[i]);
            end
        end
        total++;
        if (char_code !== 6'd10 || char_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: code=%0d vld=%b, want 10/0", char_code, char_valid);
        end
    endtask

    task automatic test_star();
        do_reset();
        send("...", 30, 1'b0);
        send("-", 30, 1'b0);
        send(".-", 30, 1'b0);
        send(".-.", 40, 1'b0);
        total++;
        if (seg_out !== model_seg()) begin
            bad++;
            $display("FAIL star_display: seg=%h, want %h", seg_out, model_seg());
        end
        send(".", 40, 1'b0);
        total++;
        if (got_code.size() != exp_code.size()) begin
            bad++;
            $display("FAIL star_count: got %0d pulses, want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            total++;
            if (got_code[i] !== exp_code[i] || got_seg[i] !== exp_seg[i]) begin
                bad++;
                $display("FAIL star_entry%0d: code %0d seg %h, want %0d seg %h", i, got_code[i], got_seg[i], exp_code[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(10, 10);
            if (i == 4) begin
                total++;
                if (overflow !== 1'b0 || sym_count !== 3'd5) begin
                    bad++;
                    $display("FAIL ovf_at_max: ovf=%b sym=%0d, want 0/5", overflow, sym_count);
                end
            end
        end
        total++;
        if (overflow !== 1'b1 || sym_count !== 3'd5) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b sym=%0d, want 1/5", overflow, sym_count);
        end
        repeat (30) @(negedge clk);
        model_emit(37);
        total++;
        if (got_code.size() != exp_code.size()) begin
            bad++;
            $display("FAIL ovf_count: got %0d pulses, want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            total++;
            if (got_code[i] !== exp_code[i] || got_seg[i] !== exp_seg[i]) begin
                bad++;
                $display("FAIL ovf_entry%0d: code %0d seg %h, want %0d seg %h", i, got_code[i], got_seg[i], exp_code[i], exp_seg[i]);
            end
        end
        total++;
        if (overflow !== 1'b0 || sym_count !== 3'd0) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b sym=%0d, want 0/0", overflow, sym_count);
        end
    endtask

    task automatic test_space();
        do_reset();
        send(".", 80, 1'b0);
        repeat (100) @(negedge clk);
        total++;
        if (got_code.size() != exp_code.size()) begin
            bad++;
            $display("FAIL space_count: got %0d pulses, want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            total++;
            if (got_code[i] !== exp_code[i] || got_seg[i] !== exp_seg[i]) begin
                bad++;
                $display("FAIL space_entry%0d: code %0d seg %h, want %0d seg %h", i, got_code[i], got_seg[i], exp_code[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send("...", 30, 1'b0);
        send("-", 30, 1'b0);
        send(".-", 30, 1'b0);
        send(".-.", 40, 1'b0);
        total++;
        if (seg_out !== model_seg()) begin
            bad++;
            $display("FAIL midrst_full: seg=%h, want %h", seg_out, model_seg());
        end
        for (int i = 0; i < 3; i++) press(10, 10);
        total++;
        if (sym_count !== 3'd3) begin
            bad++;
            $display("FAIL midrst_pending: sym=%0d, want 3", sym_count);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (seg_out !== '0 || char_code !== 6'd36 || sym_count !== 3'd0 || overflow !== 1'b0 || char_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_values: seg=%h code=%0d sym=%0d ovf=%b vld=%b, want 0/36/0/0/0", seg_out, char_code, sym_count, overflow, char_valid);
        end
        for (int i = 0; i < ND; i++) mdig[i] = '0;
        got_code.delete(); got_seg.delete(); exp_code.delete(); exp_seg.delete();
        press(30, 10);
        total++;
        if (sym_count !== 3'd1) begin
            bad++;
            $display("FAIL midrst_restart: sym=%0d, want 1", sym_count);
        end
        repeat (30) @(negedge clk);
        model_emit(29);
        total++;
        if (got_code.size() != exp_code.size()) begin
            bad++;
            $display("FAIL midrst_count: got %0d pulses, want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            total++;
            if (got_code[i] !== exp_code[i] || got_seg[i] !== exp_seg[i]) begin
                bad++;
                $display("FAIL midrst_entry%0d: code %0d seg %h, want %0d seg %h", i, got_code[i], got_seg[i], exp_code[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 14; n++) begin
            string pat;
            int    k;
            int    gap;
            k = $urandom_range(39, 0);
            if (k < 36)       pat = morse_tab[k];
            else if (k == 36) pat = "..--";
            else if (k == 37) pat = "---.";
            else if (k == 38) pat = "......";
            else              pat = "-.-.-.-";
            gap = ($urandom_range(3, 0) == 0) ? $urandom_range(90, 70) : $urandom_range(69, 30);
            if (n == 13) gap = 90;
            send(pat, gap, 1'b1);
        end
        repeat (20) @(negedge clk);
        total++;
        if (got_code.size() != exp_code.size()) begin
            bad++;
            $display("FAIL random_count: got %0d pulses, want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            total++;
            if (got_code[i] !== exp_code[i] || got_seg[i] !== exp_seg[i]) begin
                bad++;
                $display("FAIL random_entry%0d: code %0d seg %h, want %0d seg %h", i, got_code[i], got_seg[i], exp_code[i], exp_seg[i]);
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        button = 1'b0;
        test_reset();
        test_single();
        test_star();
        test_overflow();
        test_space();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_rx_buffer.md
# morse_rx_buffer

Parametrised single-button Morse receiver that replaces the fixed 8-bit capture/decode pair. It debounces the key and classifies dots and dashes by measured press duration. It detects character and word gaps from release duration, decodes variable-length symbols to alphanumerics, and shifts decoded glyphs into an N-digit seven-segment display buffer. It sits between the board push-button and the display driver pins.

## Interface
- `UNIT_CYCLES`, default 5_000_000: clock cycles per Morse dot unit (≥4).
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronised input must be stable before it is accepted (≥1).
- `MAX_SYMBOLS`, default 5: longest accepted symbol, in elements (1..7).
- `NUM_DIGITS`, default 4: number of display digits held (1..8).
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `button`, in, 1: raw key; 1 means pressed; asynchronous.
- `seg_out`, out, 7*NUM_DIGITS: digit i occupies bits [7i+6:7i], ordered {g,f,e,d,c,b,a}, 1 means lit; digit 0 is the newest.
- `char_valid`, out, 1: one-cycle pulse when a character or word space is appended.
- `char_code`, out, 6: code of the appended entry; holds its value between pulses.
- `sym_count`, out, 3: elements captured in the current, not yet complete, character.
- `overflow`, out, 1: current character exceeded MAX_SYMBOLS; clears on the next emission.

## Operation
- Input path:
  - 2-flop synchroniser on `button`.
  - Debouncer: the debounced level `key` changes only after the synchronised input differs from `key` for DEBOUNCE_CYCLES consecutive cycles.
- Press timing: `press_cnt` counts cycles while `key`=1 and saturates at 2*UNIT_CYCLES. On the falling edge of `key`:
  - press_cnt < 2*UNIT_CYCLES: dot (0).
  - Otherwise: dash (1).
  - The element is shifted into the symbol register (LSB = latest) and `sym_count` increments.
  - If `sym_count` is already MAX_SYMBOLS, the element is dropped, `overflow` is set and `sym_count` holds.
- Gap timing: `gap_cnt` clears on the rising edge of `key`, counts while `key`=0 and saturates at 7*UNIT_CYCLES.
- State machine, states IDLE, PRESS, GAP, WORD:
  - IDLE→PRESS on `key` rising.
  - PRESS→GAP on `key` falling.
  - GAP→PRESS on `key` rising before gap_cnt reaches 3*UNIT_CYCLES.
  - GAP→WORD when gap_cnt reaches 3*UNIT_CYCLES: emit the character.
  - WORD→IDLE when gap_cnt reaches 7*UNIT_CYCLES: emit SPACE.
  - WORD→PRESS on `key` rising.
- Character emission:
  - Decode {sym_count, symbol} against the table: A–Z and 0–9 per ITU.
  - Codes: 0–9 are digits, 10–35 are A–Z, 36 is SPACE, 37 is ERR.
  - Unknown pattern or `overflow`=1 gives ERR.
  - `sym_count`, the symbol register and `overflow` clear.
- Display: on every emission, all digits shift up by one and digit 0 takes the glyph of `char_code`. The oldest digit is discarded.
  - SPACE glyph: 7'b0000000.
  - ERR glyph: segment g only, 7'b1000000.
- SPACE is emitted at most once per idle period. It is never emitted after reset before the first character.

## Timing
- Reset values:
  - `seg_out`=0 (all blank), `char_valid`=0, `char_code`=36, `sym_count`=0, `overflow`=0.
  - State is IDLE, all counters are 0, and `key`=0.
- Reset mid-operation discards the partial character and clears the display on the same edge.
- Latency, button to `key`: 2 synchroniser cycles + DEBOUNCE_CYCLES.
- Element capture: `sym_count` updates on the cycle after `key` falls.
- `char_valid`, `char_code` and the `seg_out` shift are all registered and update together. This happens on the cycle after gap_cnt reaches 3*UNIT_CYCLES (character) or 7*UNIT_CYCLES (SPACE).
- Simultaneous events:
  - If `key` rises in the same cycle that gap_cnt reaches 3*UNIT_CYCLES, the character emission wins and the press starts a new character.
  - If `key` rises in the same cycle that gap_cnt reaches 7*UNIT_CYCLES, SPACE is still emitted.
- A press of saturated length, however long, is a dash. No character is emitted while `key`=1.

## Structure
- Package `morse_pkg` holds:
  - Code constants: CODE_SPACE=36, CODE_ERR=37.
  - The decode function from {len, bits} to code.
  - The glyph function from code to 7-bit segments.
  - The FSM state enum.
- One sub-module, `morse_debounce`, contains the synchroniser and debouncer and outputs `key`. It is parametrised by DEBOUNCE_CYCLES.
- The top block holds the counters, FSM, symbol register and display shift register.

## Test plan
All scenarios use UNIT_CYCLES=10, DEBOUNCE_CYCLES=2, MAX_SYMBOLS=5, NUM_DIGITS=4.
- Reset, then idle 200 cycles → `seg_out`=0, no `char_valid` pulse, `char_code`=36.
- Press 10 cycles then 30 cycles (gap 10), then release 40 → one pulse with code 10 (A). Digit 0 shows the A glyph; digits 1–3 stay blank.
- Send S, T, A, R, with 30-cycle gaps between characters → four pulses with codes 28, 29, 10, 27. `seg_out` holds digits 3..0 = S,T,A,R. A fifth character, E, shifts S out.
- Six dots with 10-cycle gaps → `overflow`=1 after the 6th. The emission gives code 37 with glyph 7'b1000000, and `overflow` clears.
- E then 80 idle cycles → pulse with code 14, then exactly one SPACE pulse (code 36) at gap 70. No further pulses follow.
- Assert `rst`=0 for 1 cycle with sym_count=3 pending and the display full → all outputs return to reset values. The next character starts from sym_count 0.
